wb_stage_pipe: RTL and testbench

- Parametrised MEM/WB pipeline register plus writeback data path for the in-order RISC-V core.
- Captures MEM-stage results and extracts and extends load data by size/sign.
- Selects the writeback source and drives the register-file write port one cycle after capture.
- Supports stall and flush, and suppresses writes to x0.

---
 rtl/wb_stage_pipe.sv | 94 +++++++++
 tb/tb_wb_stage_pipe.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_pipe.sv
// MEM/WB pipeline register with load extraction and writeback source select.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module wb_stage_pipe #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned REG_AW = 5
`ifdef WB_RETIRE_CNT_EN
  ,
  parameter int unsigned CNT_W  = 64
`endif
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic                        stall,
  input  logic                        flush,
  input  logic [1:0]                  wb_sel,
  input  logic [XLEN-1:0]             alu_res,
  input  logic [XLEN-1:0]             mem_data,
  input  logic [$clog2(XLEN/8)-1:0]   addr_lo,
  input  logic [2:0]                  ld_funct3,
  input  logic [XLEN-1:0]             npc,
  input  logic [REG_AW-1:0]           rd_addr_in,
  input  logic                        rd_we_in,
  output logic                        wb_valid,
  output logic                        rd_we,
  output logic [REG_AW-1:0]           rd_addr,
  output logic [XLEN-1:0]             rd_data
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0]            retire_cnt
`endif
);

  logic [XLEN-1:0] sh;
  logic [XLEN-1:0] ld_val;
  logic [XLEN-1:0] wb_data;

  // Align the addressed byte to bit 0, then extend by size and sign.
  always_comb begin
    sh     = mem_data >> {addr_lo, 3'b000};
    ld_val = sh;
    case (ld_funct3)
      3'b000:  ld_val = XLEN'($signed(sh[7:0]));
      3'b001:  ld_val = XLEN'($signed(sh[15:0]));
      3'b010:  ld_val = XLEN'($signed(sh[31:0]));
      3'b100:  ld_val = XLEN'(sh[7:0]);
      3'b101:  ld_val = XLEN'(sh[15:0]);
      3'b110:  ld_val = XLEN'(sh[31:0]);
      // 011/111 are LD; on XLEN=32 the full shifted word is exactly LW
      default: ld_val = sh;
    endcase
  end

  always_comb begin
    wb_data = '0;
    case (wb_sel)
      2'b01:   wb_data = alu_res;
      2'b10:   wb_data = ld_val;
      2'b11:   wb_data = npc;
      default: wb_data = '0;
    endcase
  end

  // Write enable is resolved at capture so every output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid <= 1'b0;
      rd_we    <= 1'b0;
      rd_addr  <= '0;
      rd_data  <= '0;
    end else if (flush) begin
      wb_valid <= 1'b0;
      rd_we    <= 1'b0;
    end else if (!stall) begin
      wb_valid <= in_valid;
      rd_we    <= in_valid & rd_we_in & (rd_addr_in != '0);
      rd_addr  <= rd_addr_in;
      rd_data  <= wb_data;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt <= '0;
    end else if (!flush && !stall && in_valid) begin
      retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end
`else
  // No retire counter in this build.
`endif

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Directed, table-driven bench for wb_stage_pipe (XLEN=64).
module tb_wb_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, stall, flush;
  logic [1:0]  wb_sel;
  logic [63:0] alu_res, mem_data, npc;
  logic [2:0]  addr_lo, ld_funct3;
  logic [4:0]  rd_addr_in;
  logic        rd_we_in;
  logic        wb_valid, rd_we;
  logic [4:0]  rd_addr;
  logic [63:0] rd_data;
`ifdef WB_RETIRE_CNT_EN
  logic [3:0]  retire_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_stage_pipe #(
    .XLEN(64),
    .REG_AW(5)
`ifdef WB_RETIRE_CNT_EN
    ,
    .CNT_W(4)
`endif
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
    .wb_sel(wb_sel), .alu_res(alu_res), .mem_data(mem_data), .addr_lo(addr_lo),
    .ld_funct3(ld_funct3), .npc(npc), .rd_addr_in(rd_addr_in), .rd_we_in(rd_we_in),
    .wb_valid(wb_valid), .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retire_cnt(retire_cnt)
`endif
  );

  typedef struct {
    logic        iv, st, fl;
    logic [1:0]  sel;
    logic [63:0] alu, mem;
    logic [2:0]  off, f3;
    logic [63:0] pc4;
    logic [4:0]  rd;
    logic        we;
    logic        e_valid, e_we;
    logic [4:0]  e_rd;
    logic [63:0] e_data;
    logic        chk_data;
  } vec_t;

  localparam logic [63:0] M = 64'h80FF_7F01_8000_00F0;
  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic st, input logic fl, input logic [1:0] sel,
                       input logic [63:0] alu, input logic [63:0] mem, input logic [2:0] off,
                       input logic [2:0] f3, input logic [63:0] pc4, input logic [4:0] rd,
                       input logic we);
    in_valid = iv; stall = st; flush = fl; wb_sel = sel; alu_res = alu; mem_data = mem;
    addr_lo = off; ld_funct3 = f3; npc = pc4; rd_addr_in = rd; rd_we_in = we;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input int idx, input logic v, input logic w,
                         input logic [4:0] a, input logic [63:0] d, input logic cd);
    chk({name, ".wb_valid"}, idx, 64'(wb_valid), 64'(v));
    chk({name, ".rd_we"},    idx, 64'(rd_we),    64'(w));
    if (cd) begin
      chk({name, ".rd_addr"}, idx, 64'(rd_addr), 64'(a));
      chk({name, ".rd_data"}, idx, rd_data, d);
    end
  endtask

  initial begin
    // iv st fl sel alu mem off f3 npc rd we | valid we rd data chk_data
    vecs[0]  = '{1,0,0,2'b01,64'h1234,M,3'd0,3'b000,64'h0,5'd5,1, 1,1,5'd5,64'h1234,1};
    vecs[1]  = '{1,0,0,2'b10,64'h0,M,3'd1,3'b000,64'h0,5'd6,1, 1,1,5'd6,64'h0,1};
    vecs[2]  = '{1,0,0,2'b10,64'h0,M,3'd0,3'b000,64'h0,5'd6,1, 1,1,5'd6,64'hFFFF_FFFF_FFFF_FFF0,1};
    vecs[3]  = '{1,0,0,2'b10,64'h0,M,3'd0,3'b100,64'h0,5'd6,1, 1,1,5'd6,64'hF0,1};
    vecs[4]  = '{1,0,0,2'b10,64'h0,M,3'd4,3'b010,64'h0,5'd6,1, 1,1,5'd6,64'hFFFF_FFFF_80FF_7F01,1};
    vecs[5]  = '{1,0,0,2'b10,64'h0,M,3'd4,3'b110,64'h0,5'd6,1, 1,1,5'd6,64'h80FF_7F01,1};
    vecs[6]  = '{1,0,0,2'b10,64'h0,M,3'd7,3'b001,64'h0,5'd6,1, 1,1,5'd6,64'h80,1};
    vecs[7]  = '{1,0,0,2'b10,64'h0,M,3'd2,3'b001,64'h0,5'd6,1, 1,1,5'd6,64'hFFFF_FFFF_FFFF_8000,1};
    vecs[8]  = '{1,0,0,2'b10,64'h0,M,3'd2,3'b101,64'h0,5'd6,1, 1,1,5'd6,64'h8000,1};
    vecs[9]  = '{1,0,0,2'b10,64'h0,M,3'd4,3'b011,64'h0,5'd6,1, 1,1,5'd6,64'h80FF_7F01,1};
    vecs[10] = '{1,0,0,2'b10,64'h0,M,3'd0,3'b111,64'h0,5'd6,1, 1,1,5'd6,M,1};
    vecs[11] = '{1,0,0,2'b11,64'h77,M,3'd0,3'b000,64'h104,5'd0,1, 1,0,5'd0,64'h104,1};
    vecs[12] = '{1,0,0,2'b00,64'hDEAD,M,3'd0,3'b000,64'h8,5'd7,1, 1,1,5'd7,64'h0,1};
    vecs[13] = '{0,0,0,2'b01,64'hAA,M,3'd0,3'b000,64'h0,5'd9,1, 0,0,5'd9,64'hAA,1};
    vecs[14] = '{1,0,0,2'b01,64'h55,M,3'd0,3'b000,64'h0,5'd10,0, 1,0,5'd10,64'h55,1};
    vecs[15] = '{1,1,0,2'b01,64'h999,M,3'd0,3'b000,64'h0,5'd11,1, 1,0,5'd10,64'h55,1};
    vecs[16] = '{1,0,1,2'b01,64'h321,M,3'd0,3'b000,64'h0,5'd12,1, 0,0,5'd0,64'h0,0};
    vecs[17] = '{1,0,0,2'b10,64'h0,M,3'd0,3'b010,64'h0,5'd13,1, 1,1,5'd13,64'hFFFF_FFFF_8000_00F0,1};

    // Reset with random inputs
    rst = 1'b1;
    drive(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), {$urandom, $urandom},
          {$urandom, $urandom}, 3'($urandom), 3'($urandom), {$urandom, $urandom},
          5'($urandom), 1'($urandom));
    step();
    drive(1'b1, 1'b0, 1'b0, 2'b01, 64'hFFFF, M, 3'd0, 3'd0, 64'h0, 5'd31, 1'b1);
    step();
    chk_out("reset", 0, 1'b0, 1'b0, 5'd0, 64'h0, 1'b1);
`ifdef WB_RETIRE_CNT_EN
    chk("reset.retire_cnt", 0, 64'(retire_cnt), 64'h0);
`endif
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].iv, vecs[i].st, vecs[i].fl, vecs[i].sel, vecs[i].alu, vecs[i].mem,
            vecs[i].off, vecs[i].f3, vecs[i].pc4, vecs[i].rd, vecs[i].we);
      step();
      chk_out("vec", i, vecs[i].e_valid, vecs[i].e_we, vecs[i].e_rd, vecs[i].e_data, vecs[i].chk_data);
    end

    // Load A then hold through three stalled cycles with fresh inputs
    drive(1'b1, 1'b0, 1'b0, 2'b01, 64'h7, M, 3'd0, 3'd0, 64'h0, 5'd3, 1'b1);
    step();
    chk_out("loadA", 0, 1'b1, 1'b1, 5'd3, 64'h7, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 2'b11, 64'h99, M, 3'd0, 3'd0, 64'h500 + 64'(i), 5'd20 + 5'(i), 1'b1);
      step();
      chk_out("stall", i, 1'b1, 1'b1, 5'd3, 64'h7, 1'b1);
    end
    drive(1'b1, 1'b1, 1'b1, 2'b01, 64'h44, M, 3'd0, 3'd0, 64'h0, 5'd21, 1'b1);
    step();
    chk_out("flush_stall", 0, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0);

    // Reset asserted during a stall clears everything
    drive(1'b1, 1'b0, 1'b0, 2'b01, 64'hABCD, M, 3'd0, 3'd0, 64'h0, 5'd8, 1'b1);
    step();
    chk_out("pre_rst", 0, 1'b1, 1'b1, 5'd8, 64'hABCD, 1'b1);
    stall = 1'b1;
    rst   = 1'b1;
    step();
    chk_out("rst_stall", 0, 1'b0, 1'b0, 5'd0, 64'h0, 1'b1);
    rst = 1'b0;

`ifdef WB_RETIRE_CNT_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 1'b0, 2'b01, 64'(i), M, 3'd0, 3'd0, 64'h0, 5'd1, 1'(i));
      step();
    end
    drive(1'b1, 1'b1, 1'b0, 2'b01, 64'h0, M, 3'd0, 3'd0, 64'h0, 5'd1, 1'b1);
    step();
    step();
    drive(1'b1, 1'b0, 1'b1, 2'b01, 64'h0, M, 3'd0, 3'd0, 64'h0, 5'd1, 1'b1);
    step();
    chk("cnt10", 0, 64'(retire_cnt), 64'd10);
    drive(1'b1, 1'b0, 1'b0, 2'b01, 64'h0, M, 3'd0, 3'd0, 64'h0, 5'd1, 1'b1);
    for (int i = 0; i < 5; i++) step();
    chk("cnt15", 0, 64'(retire_cnt), 64'd15);
    step();
    chk("cnt_wrap", 0, 64'(retire_cnt), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
